// File: rtl/cmp_arbiter_if.sv
// Handshake bundle for the shared compare unit: two requesters and one response channel.
// The master side drives requests and consumes responses; the slave side is the arbiter.
interface cmp_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_op;
  logic [15:0] a_opnd_x;
  logic [15:0] a_opnd_y;

  logic        b_valid;
  logic        b_ready;
  logic [2:0]  b_op;
  logic [15:0] b_opnd_x;
  logic [15:0] b_opnd_y;

  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic        resp_result;
  logic        resp_err;

  modport master (
    output a_valid, a_op, a_opnd_x, a_opnd_y,
    input  a_ready,
    output b_valid, b_op, b_opnd_x, b_opnd_y,
    input  b_ready,
    input  resp_valid, resp_id, resp_result, resp_err,
    output resp_ready
  );

  modport slave (
    input  a_valid, a_op, a_opnd_x, a_opnd_y,
    output a_ready,
    input  b_valid, b_op, b_opnd_x, b_opnd_y,
    output b_ready,
    output resp_valid, resp_id, resp_result, resp_err,
    input  resp_ready
  );
endinterface

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter feeding one shared 16-bit signed comparator through a
// two-stage pipeline (S1 = operands, S2 = result driving the response channel).
module cmp_arbiter (
  input  logic          clk,
  input  logic          rst_n,
  cmp_arbiter_if.slave  bus
);

  localparam logic [2:0] OP_EQ  = 3'b000;
  localparam logic [2:0] OP_NE  = 3'b001;
  localparam logic [2:0] OP_LT  = 3'b010;
  localparam logic [2:0] OP_LTE = 3'b011;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // Requesters as index 0 (A) and 1 (B)
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  req_op   [2];
  logic [15:0] req_x    [2];
  logic [15:0] req_y    [2];

  logic [1:0]  grant;
  logic        accept;
  logic        accept_id;

  logic        last_grant_reg;

  logic        s1_valid_reg;
  logic        s1_owner_reg;
  logic [2:0]  s1_op_reg;
  logic [15:0] s1_x_reg;
  logic [15:0] s1_y_reg;

  logic        s2_valid_reg;
  logic        s2_owner_reg;
  logic        s2_result_reg;
  logic        s2_err_reg;

  logic        s2_result_next;
  logic        s2_err_next;

  logic        s1_adv;
  logic        s2_adv;

  assign req_valid = {bus.b_valid, bus.a_valid};
  assign req_op[0] = bus.a_op;
  assign req_op[1] = bus.b_op;
  assign req_x[0]  = bus.a_opnd_x;
  assign req_x[1]  = bus.b_opnd_x;
  assign req_y[0]  = bus.a_opnd_y;
  assign req_y[1]  = bus.b_opnd_y;

  assign s2_adv = !s2_valid_reg || bus.resp_ready;
  assign s1_adv = !s1_valid_reg || s2_adv;

  always_comb begin
    grant = 2'b00;
    if (req_valid[0] && req_valid[1]) begin
      grant = (last_grant_reg == OWNER_B) ? 2'b01 : 2'b10;
    end else begin
      grant = req_valid;
    end
  end

  // Ready is held low while in reset so nothing is accepted on a reset edge
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = rst_n && grant[gi] && s1_adv;
    end
  endgenerate

  assign bus.a_ready = req_ready[0];
  assign bus.b_ready = req_ready[1];

  assign accept    = |(req_valid & req_ready);
  assign accept_id = grant[1] ? OWNER_B : OWNER_A;

  // Shared subtractor and condition evaluation on the S1 contents
  logic [15:0] diff;
  logic        zero;
  logic        ovf;
  logic        lt;

  always_comb begin
    diff = s1_x_reg - s1_y_reg;
    zero = (diff == 16'h0000);
    ovf  = (s1_x_reg[15] ^ s1_y_reg[15]) & (diff[15] ^ s1_x_reg[15]);
    lt   = diff[15] ^ ovf;

    s2_result_next = 1'b0;
    s2_err_next    = 1'b0;
    case (s1_op_reg)
      OP_EQ:   s2_result_next = zero;
      OP_NE:   s2_result_next = !zero;
      OP_LT:   s2_result_next = lt;
      OP_LTE:  s2_result_next = lt | zero;
      default: s2_err_next    = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_reg <= OWNER_B;
      s1_valid_reg   <= 1'b0;
      s1_owner_reg   <= OWNER_A;
      s1_op_reg      <= 3'b000;
      s1_x_reg       <= 16'h0000;
      s1_y_reg       <= 16'h0000;
      s2_valid_reg   <= 1'b0;
      s2_owner_reg   <= OWNER_A;
      s2_result_reg  <= 1'b0;
      s2_err_reg     <= 1'b0;
    end else begin
      if (accept) begin
        last_grant_reg <= accept_id;
      end

      if (s1_adv) begin
        s1_valid_reg <= accept;
        if (accept) begin
          s1_owner_reg <= accept_id;
          s1_op_reg    <= req_op[accept_id];
          s1_x_reg     <= req_x[accept_id];
          s1_y_reg     <= req_y[accept_id];
        end
      end

      // S2 payload only changes when a new result enters, so a stalled response stays put
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_owner_reg  <= s1_owner_reg;
          s2_result_reg <= s2_result_next;
          s2_err_reg    <= s2_err_next;
        end
      end
    end
  end

  assign bus.resp_valid  = s2_valid_reg;
  assign bus.resp_id     = s2_owner_reg;
  assign bus.resp_result = s2_result_reg;
  assign bus.resp_err    = s2_err_reg;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: reset, arbitration order, compare results,
// backpressure and mid-flight reset, with hand-computed expectations.
module tb_cmp_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cmp_arbiter_if bus();

  cmp_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit is_b, input logic valid, input logic [2:0] op,
                         input logic [15:0] x, input logic [15:0] y);
    if (is_b) begin
      bus.b_valid = valid; bus.b_op = op; bus.b_opnd_x = x; bus.b_opnd_y = y;
    end else begin
      bus.a_valid = valid; bus.a_op = op; bus.a_opnd_x = x; bus.a_opnd_y = y;
    end
  endtask

  task automatic check_resp(input string tag, input logic id, input logic res, input logic err);
    $display("resp %s: valid=%0b id=%0b result=%0b err=%0b", tag,
             bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_err);
    chk({tag, "_valid"},  32'(bus.resp_valid),  32'(1'b1));
    chk({tag, "_id"},     32'(bus.resp_id),     32'(id));
    chk({tag, "_result"}, 32'(bus.resp_result), 32'(res));
    chk({tag, "_err"},    32'(bus.resp_err),    32'(err));
  endtask

  // One isolated request from a single requester with an empty pipeline
  task automatic single(input string tag, input bit is_b, input logic [2:0] op,
                        input logic [15:0] x, input logic [15:0] y,
                        input logic exp_res, input logic exp_err);
    set_req(is_b, 1'b1, op, x, y);
    settle();
    chk({tag, "_ready"}, 32'(is_b ? bus.b_ready : bus.a_ready), 32'(1'b1));
    tick();
    set_req(is_b, 1'b0, op, x, y);
    settle();
    chk({tag, "_lat1"}, 32'(bus.resp_valid), 32'(1'b0));
    tick();
    check_resp(tag, is_b, exp_res, exp_err);
    tick();
    chk({tag, "_drain"}, 32'(bus.resp_valid), 32'(1'b0));
  endtask

  int accepts;

  initial begin
    rst_n          = 1'b0;
    bus.resp_ready = 1'b1;
    set_req(1'b0, 1'b1, 3'b000, 16'h0005, 16'h0005);
    set_req(1'b1, 1'b1, 3'b001, 16'h0005, 16'h0005);
    tick();
    tick();
    chk("rst_resp_valid",  32'(bus.resp_valid),  0);
    chk("rst_resp_id",     32'(bus.resp_id),     0);
    chk("rst_resp_result", 32'(bus.resp_result), 0);
    chk("rst_resp_err",    32'(bus.resp_err),    0);
    chk("rst_a_ready",     32'(bus.a_ready),     0);
    chk("rst_b_ready",     32'(bus.b_ready),     0);

    // Contention right after reset: A (EQ 5,5 -> 1) and B (NE 5,5 -> 0) alternate
    rst_n = 1'b1;
    settle();
    chk("rr0_a_ready", 32'(bus.a_ready), 1);
    chk("rr0_b_ready", 32'(bus.b_ready), 0);
    tick();
    chk("rr1_a_ready", 32'(bus.a_ready), 0);
    chk("rr1_b_ready", 32'(bus.b_ready), 1);
    chk("rr1_resp_valid", 32'(bus.resp_valid), 0);
    tick();
    check_resp("rr_resp0", 1'b0, 1'b1, 1'b0);
    chk("rr2_a_ready", 32'(bus.a_ready), 1);
    tick();
    check_resp("rr_resp1", 1'b1, 1'b0, 1'b0);
    chk("rr3_b_ready", 32'(bus.b_ready), 1);
    tick();
    check_resp("rr_resp2", 1'b0, 1'b1, 1'b0);
    set_req(1'b0, 1'b0, 3'b000, 16'h0005, 16'h0005);
    set_req(1'b1, 1'b0, 3'b001, 16'h0005, 16'h0005);
    tick();
    check_resp("rr_resp3", 1'b1, 1'b0, 1'b0);
    tick();
    chk("rr_drain", 32'(bus.resp_valid), 0);

    // Compare functions, including signed-overflow cases and reserved ops
    single("a_lt_ovf",   1'b0, 3'b010, 16'h8000, 16'h7FFF, 1'b1, 1'b0);
    single("a_lt_ovf_r", 1'b0, 3'b010, 16'h7FFF, 16'h8000, 1'b0, 1'b0);
    single("a_lte_neg",  1'b0, 3'b011, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
    single("a_lt_pos",   1'b0, 3'b010, 16'h0003, 16'hFFFE, 1'b0, 1'b0);
    single("b_lte_eq",   1'b1, 3'b011, 16'h1234, 16'h1234, 1'b1, 1'b0);
    single("b_ne_eq",    1'b1, 3'b001, 16'h1234, 16'h1234, 1'b0, 1'b0);
    single("b_rsv5",     1'b1, 3'b101, 16'h1234, 16'h1234, 1'b0, 1'b1);
    single("a_rsv7",     1'b0, 3'b111, 16'h0000, 16'h0001, 1'b0, 1'b1);

    // Backpressure: A streams EQ x=k+1,y=1 for 5 cycles with the consumer stalled
    accepts = 0;
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_req(1'b0, 1'b1, 3'b000, 16'(k + 1), 16'h0001);
      settle();
      if (bus.a_valid && bus.a_ready) accepts++;
      chk($sformatf("bp_ready%0d", k), 32'(bus.a_ready), 32'(k < 2));
      if (k >= 2) check_resp($sformatf("bp_hold%0d", k), 1'b0, 1'b1, 1'b0);
      tick();
    end
    chk("bp_accepts", 32'(accepts), 2);
    set_req(1'b0, 1'b0, 3'b000, 16'h0000, 16'h0000);
    bus.resp_ready = 1'b1;
    settle();
    check_resp("bp_drain0", 1'b0, 1'b1, 1'b0);
    tick();
    check_resp("bp_drain1", 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_empty", 32'(bus.resp_valid), 0);

    // Reset with both stages full; A was granted last, so reset must restore A priority
    bus.resp_ready = 1'b0;
    set_req(1'b0, 1'b1, 3'b000, 16'h0009, 16'h0001);
    tick();
    tick();
    rst_n = 1'b0;
    set_req(1'b0, 1'b1, 3'b000, 16'h0007, 16'h0007);
    set_req(1'b1, 1'b1, 3'b101, 16'h0007, 16'h0007);
    settle();
    chk("mr_full_valid", 32'(bus.resp_valid), 1);
    chk("mr_a_ready",    32'(bus.a_ready), 0);
    chk("mr_b_ready",    32'(bus.b_ready), 0);
    tick();
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    settle();
    chk("mr_cleared",    32'(bus.resp_valid), 0);
    chk("mr_a_wins",     32'(bus.a_ready), 1);
    chk("mr_b_waits",    32'(bus.b_ready), 0);
    tick();
    set_req(1'b0, 1'b0, 3'b000, 16'h0000, 16'h0000);
    set_req(1'b1, 1'b0, 3'b000, 16'h0000, 16'h0000);
    settle();
    chk("mr_no_stale",   32'(bus.resp_valid), 0);
    tick();
    check_resp("mr_resp", 1'b0, 1'b1, 1'b0);
    tick();
    chk("mr_empty", 32'(bus.resp_valid), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
